// File: rtl/mmc_sched_pkg.sv
// Shared definitions for the per-channel DFI command scheduler: command
// encodings, FSM state type and the latched request record.
package mmc_sched_pkg;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  localparam int SCHED_BANK_W = 2;
  localparam int SCHED_ADDR_W = 12;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_PRE        = 3'd2,
    ST_WAIT_RP    = 3'd3,
    ST_ACT        = 3'd4,
    ST_WAIT_RCD   = 3'd5,
    ST_ACCESS     = 3'd6,
    ST_WAIT_BURST = 3'd7
  } sched_state_e;

  typedef struct packed {
    logic [SCHED_BANK_W-1:0] bank;
    logic [SCHED_ADDR_W-1:0] row;
    logic [SCHED_ADDR_W-1:0] col;
    logic                    is_wr;
  } sched_req_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mmc_bank_page_table.sv
// Open-page tracker: one {open,row} entry per bank, classified on lookup as
// hit / closed / conflict (neither hit nor closed).
module mmc_bank_page_table #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              clear_all,
  input  logic [BANK_W-1:0] lookup_bank,
  input  logic [ADDR_W-1:0] lookup_row,
  output logic              lookup_hit,
  output logic              lookup_closed,
  input  logic              upd_valid,
  input  logic              upd_open,
  input  logic [BANK_W-1:0] upd_bank,
  input  logic [ADDR_W-1:0] upd_row
);
  import mmc_sched_pkg::*;

  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [ADDR_W-1:0]    row_q [NUM_BANKS];
  logic [ADDR_W-1:0]    row_d [NUM_BANKS];

  assign lookup_closed = ~open_q[lookup_bank];
  assign lookup_hit    = open_q[lookup_bank] & (row_q[lookup_bank] == lookup_row);

  // Next table contents: bulk close wins over a single-entry ACT/PRE update.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (clear_all) begin
      open_d = '0;
    end else if (upd_valid) begin
      open_d[upd_bank] = upd_open;
      if (upd_open) begin
        row_d[upd_bank] = upd_row;
      end else begin
        row_d[upd_bank] = row_q[upd_bank];
      end
    end else begin
      open_d = open_q;
    end
  end

  // Table registers.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      open_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/mmc_dfi_cmd_sched.sv
// Per-channel DFI command scheduler: round-robin read/write arbitration, page
// tracking and PRE/ACT/RD/WR sequencing with T_RP/T_RCD/T_BURST spacing.
module mmc_dfi_cmd_sched
  import mmc_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int ADDR_W    = 12,
  parameter int T_RP      = 3,
  parameter int T_RCD     = 3,
  parameter int T_BURST   = 2
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              dfi__mmc__init_done,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [BANK_W-1:0] rd_req_bank,
  input  logic [ADDR_W-1:0] rd_req_row,
  input  logic [ADDR_W-1:0] rd_req_col,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [BANK_W-1:0] wr_req_bank,
  input  logic [ADDR_W-1:0] wr_req_row,
  input  logic [ADDR_W-1:0] wr_req_col,
  output logic              wr_data_pop,
  output logic              mmc__dfi__cs,
  output logic              mmc__dfi__cmd1,
  output logic              mmc__dfi__cmd0,
  output logic [BANK_W-1:0] mmc__dfi__bank,
  output logic [ADDR_W-1:0] mmc__dfi__addr,
  output logic              sched_idle
);

  localparam int   TMR_W = $clog2(max3(T_RP, T_RCD, T_BURST)) + 1;
  localparam logic RR_RD = 1'b0;
  localparam logic RR_WR = 1'b1;

  sched_state_e     state_q, state_d;
  logic             rr_q, rr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  sched_req_t       req_q, req_d, req_in;
  logic             rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic             cs_q, cs_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic             pop_q, pop_d, idle_q, idle_d;
  logic             rd_acc, wr_acc, accept;
  logic             pt_hit, pt_closed, clear_all, upd_valid, upd_open;

  mmc_bank_page_table #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W),
    .ADDR_W    (ADDR_W)
  ) u_page_table (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .clear_all     (clear_all),
    .lookup_bank   (BANK_W'(req_in.bank)),
    .lookup_row    (ADDR_W'(req_in.row)),
    .lookup_hit    (pt_hit),
    .lookup_closed (pt_closed),
    .upd_valid     (upd_valid),
    .upd_open      (upd_open),
    .upd_bank      (BANK_W'(req_d.bank)),
    .upd_row       (ADDR_W'(req_d.row))
  );

  // Handshake and selection of the request accepted this cycle.
  always_comb begin
    rd_acc = rd_req_valid & rd_ready_q;
    wr_acc = wr_req_valid & wr_ready_q;
    accept = rd_acc | wr_acc;
    req_in = '0;
    if (wr_acc) begin
      req_in.bank  = SCHED_BANK_W'(wr_req_bank);
      req_in.row   = SCHED_ADDR_W'(wr_req_row);
      req_in.col   = SCHED_ADDR_W'(wr_req_col);
      req_in.is_wr = 1'b1;
    end else begin
      req_in.bank  = SCHED_BANK_W'(rd_req_bank);
      req_in.row   = SCHED_ADDR_W'(rd_req_row);
      req_in.col   = SCHED_ADDR_W'(rd_req_col);
      req_in.is_wr = 1'b0;
    end
    if (accept) begin
      req_d = req_in;
    end else begin
      req_d = req_q;
    end
  end

  // Sequencing FSM; every command state lasts one cycle and arms the timer,
  // which hands over to the next state when it reads 1.
  always_comb begin
    state_d   = state_q;
    clear_all = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (dfi__mmc__init_done) state_d = ST_IDLE;
        else                     state_d = ST_INIT;
      end
      ST_IDLE: begin
        if (accept) begin
          if (pt_hit)         state_d = ST_ACCESS;
          else if (pt_closed) state_d = ST_ACT;
          else                state_d = ST_PRE;
        end else if (!dfi__mmc__init_done) begin
          state_d   = ST_INIT;
          clear_all = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE, ST_WAIT_RP: begin
        if (timer_q == TMR_W'(1)) state_d = ST_ACT;
        else                      state_d = ST_WAIT_RP;
      end
      ST_ACT, ST_WAIT_RCD: begin
        if (timer_q == TMR_W'(1)) state_d = ST_ACCESS;
        else                      state_d = ST_WAIT_RCD;
      end
      ST_ACCESS, ST_WAIT_BURST: begin
        if (timer_q != TMR_W'(1)) begin
          state_d = ST_WAIT_BURST;
        end else if (dfi__mmc__init_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_INIT;
          clear_all = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    case (state_d)
      ST_PRE:    timer_d = TMR_W'(T_RP);
      ST_ACT:    timer_d = TMR_W'(T_RCD);
      ST_ACCESS: timer_d = TMR_W'(T_BURST);
      default: begin
        if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
        else               timer_d = '0;
      end
    endcase
  end

  // Round-robin pointer moves only when both sides competed for the grant.
  always_comb begin
    if (accept && rd_req_valid && wr_req_valid) begin
      rr_d = rd_acc ? RR_WR : RR_RD;
    end else begin
      rr_d = rr_q;
    end
    rd_ready_d = 1'b0;
    wr_ready_d = 1'b0;
    if ((state_d == ST_IDLE) && dfi__mmc__init_done) begin
      if (rd_req_valid && wr_req_valid) begin
        rd_ready_d = (rr_d == RR_RD);
        wr_ready_d = (rr_d == RR_WR);
      end else begin
        rd_ready_d = rd_req_valid;
        wr_ready_d = wr_req_valid;
      end
    end else begin
      rd_ready_d = 1'b0;
    end
  end

  // DFI command and page-table update decoded from the state being entered.
  always_comb begin
    cs_d      = 1'b0;
    cmd_d     = 2'b00;
    bank_d    = '0;
    addr_d    = '0;
    pop_d     = 1'b0;
    upd_valid = 1'b0;
    upd_open  = 1'b0;
    idle_d    = (state_d == ST_IDLE);
    case (state_d)
      ST_PRE: begin
        cs_d      = 1'b1;
        cmd_d     = CMD_PRE;
        bank_d    = BANK_W'(req_d.bank);
        upd_valid = 1'b1;
      end
      ST_ACT: begin
        cs_d      = 1'b1;
        cmd_d     = CMD_ACT;
        bank_d    = BANK_W'(req_d.bank);
        addr_d    = ADDR_W'(req_d.row);
        upd_valid = 1'b1;
        upd_open  = 1'b1;
      end
      ST_ACCESS: begin
        cs_d   = 1'b1;
        cmd_d  = req_d.is_wr ? CMD_WR : CMD_RD;
        bank_d = BANK_W'(req_d.bank);
        addr_d = ADDR_W'(req_d.col);
        pop_d  = req_d.is_wr;
      end
      default: cs_d = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q    <= ST_INIT;
      rr_q       <= RR_RD;
      timer_q    <= '0;
      req_q      <= '0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      cs_q       <= 1'b0;
      cmd_q      <= 2'b00;
      bank_q     <= '0;
      addr_q     <= '0;
      pop_q      <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      timer_q    <= timer_d;
      req_q      <= req_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      cs_q       <= cs_d;
      cmd_q      <= cmd_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      pop_q      <= pop_d;
      idle_q     <= idle_d;
    end
  end

  assign rd_req_ready   = rd_ready_q;
  assign wr_req_ready   = wr_ready_q;
  assign wr_data_pop    = pop_q;
  assign mmc__dfi__cs   = cs_q;
  assign mmc__dfi__cmd1 = cmd_q[1];
  assign mmc__dfi__cmd0 = cmd_q[0];
  assign mmc__dfi__bank = bank_q;
  assign mmc__dfi__addr = addr_q;
  assign sched_idle     = idle_q;

endmodule

// File: tb/tb_mmc_dfi_cmd_sched.sv
// Directed bench for mmc_dfi_cmd_sched: cycle-by-cycle expected DFI/handshake
// vectors for closed, hit, conflict, arbitration, reset and init-drop cases.
module tb_mmc_dfi_cmd_sched;
  import mmc_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset_poweron = 1'b1;
  logic        init_done = 1'b0;
  logic        rd_req_valid = 1'b0, wr_req_valid = 1'b0;
  logic        rd_req_ready, wr_req_ready;
  logic [1:0]  rd_req_bank = 2'd0, wr_req_bank = 2'd0;
  logic [11:0] rd_req_row = 12'h000, rd_req_col = 12'h000;
  logic [11:0] wr_req_row = 12'h000, wr_req_col = 12'h000;
  logic        wr_data_pop, cs, cmd1, cmd0, sched_idle;
  logic [1:0]  dfi_bank;
  logic [11:0] dfi_addr;
  logic [20:0] obs;
  int          checks = 0;
  int          errors = 0;

  mmc_dfi_cmd_sched dut (
    .clk                 (clk),
    .reset_poweron       (reset_poweron),
    .dfi__mmc__init_done (init_done),
    .rd_req_valid        (rd_req_valid),
    .rd_req_ready        (rd_req_ready),
    .rd_req_bank         (rd_req_bank),
    .rd_req_row          (rd_req_row),
    .rd_req_col          (rd_req_col),
    .wr_req_valid        (wr_req_valid),
    .wr_req_ready        (wr_req_ready),
    .wr_req_bank         (wr_req_bank),
    .wr_req_row          (wr_req_row),
    .wr_req_col          (wr_req_col),
    .wr_data_pop         (wr_data_pop),
    .mmc__dfi__cs        (cs),
    .mmc__dfi__cmd1      (cmd1),
    .mmc__dfi__cmd0      (cmd0),
    .mmc__dfi__bank      (dfi_bank),
    .mmc__dfi__addr      (dfi_addr),
    .sched_idle          (sched_idle)
  );

  always #5 clk = ~clk;

  assign obs = {rd_req_ready, wr_req_ready, cs, cmd1, cmd0, dfi_bank, dfi_addr, wr_data_pop, sched_idle};

  function automatic logic [20:0] ev(input logic rr, input logic rw, input logic c, input logic [1:0] cmd,
                                     input logic [1:0] bank, input logic [11:0] addr, input logic pop,
                                     input logic idle);
    return {rr, rw, c, cmd, bank, addr, pop, idle};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 21'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 21'h0);
    end
    reset_poweron = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 21'h0) begin
      errors++;
      $display("FAIL reset_init_state: got %h expected %h", obs, 21'h0);
    end
  endtask

  task automatic test_init_hold();
    rd_req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 21'h0) begin
        errors++;
        $display("FAIL init_hold cycle %0d: got %h expected %h", i, obs, 21'h0);
      end
    end
    rd_req_valid = 1'b0;
    init_done    = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ev(1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL init_to_idle: got %h expected idle only", obs);
    end
  endtask

  task automatic test_closed_then_hit();
    logic [20:0] exp_v [0:9];
    logic        got;
    exp_v[0] = ev(1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    exp_v[1] = ev(1'b0, 1'b0, 1'b1, CMD_ACT, 2'd1, 12'h010, 1'b0, 1'b0);
    exp_v[2] = 21'h0;
    exp_v[3] = 21'h0;
    exp_v[4] = ev(1'b0, 1'b0, 1'b1, CMD_RD, 2'd1, 12'h004, 1'b0, 1'b0);
    exp_v[5] = 21'h0;
    exp_v[6] = ev(1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    exp_v[7] = ev(1'b0, 1'b0, 1'b1, CMD_RD, 2'd1, 12'h008, 1'b0, 1'b0);
    exp_v[8] = 21'h0;
    exp_v[9] = ev(1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    rd_req_bank = 2'd1; rd_req_row = 12'h010; rd_req_col = 12'h004; rd_req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rd_req_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL closed_rd_ready: got no ready within 20 cycles, expected ready");
      return;
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL closed_then_hit step %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 1) rd_req_valid = 1'b0;
      else if (i == 4) begin rd_req_col = 12'h008; rd_req_valid = 1'b1; end
      else if (i == 7) rd_req_valid = 1'b0;
    end
  endtask

  task automatic test_conflict_wr();
    logic [20:0] exp_v [0:9];
    logic        got;
    exp_v[0] = ev(1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    exp_v[1] = ev(1'b0, 1'b0, 1'b1, CMD_PRE, 2'd1, 12'h000, 1'b0, 1'b0);
    exp_v[2] = 21'h0;
    exp_v[3] = 21'h0;
    exp_v[4] = ev(1'b0, 1'b0, 1'b1, CMD_ACT, 2'd1, 12'h022, 1'b0, 1'b0);
    exp_v[5] = 21'h0;
    exp_v[6] = 21'h0;
    exp_v[7] = ev(1'b0, 1'b0, 1'b1, CMD_WR, 2'd1, 12'h000, 1'b1, 1'b0);
    exp_v[8] = 21'h0;
    exp_v[9] = ev(1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    wr_req_bank = 2'd1; wr_req_row = 12'h022; wr_req_col = 12'h000; wr_req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = wr_req_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL conflict_wr_ready: got no ready within 20 cycles, expected ready");
      return;
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL conflict_wr step %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 1) wr_req_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic       got, exp_wr;
    int         n;
    logic [20:0] exp_cmd;
    rd_req_bank = 2'd1; rd_req_row = 12'h022; rd_req_col = 12'h001;
    wr_req_bank = 2'd1; wr_req_row = 12'h022; wr_req_col = 12'h002;
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      n   = 0;
      for (int k = 0; k < 12 && !got; k++) begin
        @(negedge clk);
        n++;
        got = rd_req_ready | wr_req_ready;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL b2b_grant %0d: got no ready within 12 cycles, expected a grant", g);
        break;
      end
      exp_wr = (g % 2 == 1);
      checks++;
      if ({rd_req_ready, wr_req_ready} !== (exp_wr ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL b2b_side %0d: got rd/wr ready %b%b expected %s", g, rd_req_ready, wr_req_ready,
                 exp_wr ? "W" : "R");
      end
      if (g > 0) begin
        checks++;
        if (n !== 2) begin
          errors++;
          $display("FAIL b2b_gap %0d: got %0d cycles after access expected 2", g, n);
        end
      end
      @(negedge clk);
      exp_cmd = ev(1'b0, 1'b0, 1'b1, exp_wr ? CMD_WR : CMD_RD, 2'd1, exp_wr ? 12'h002 : 12'h001, exp_wr, 1'b0);
      checks++;
      if (obs !== exp_cmd) begin
        errors++;
        $display("FAIL b2b_cmd %0d: got %h expected %h", g, obs, exp_cmd);
      end
    end
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [20:0] exp_v [0:10];
    logic        got;
    exp_v[0]  = ev(1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    exp_v[1]  = ev(1'b0, 1'b0, 1'b1, CMD_ACT, 2'd2, 12'h033, 1'b0, 1'b0);
    exp_v[2]  = 21'h0;
    exp_v[3]  = 21'h0;
    exp_v[4]  = ev(1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    exp_v[5]  = ev(1'b0, 1'b0, 1'b1, CMD_ACT, 2'd2, 12'h033, 1'b0, 1'b0);
    exp_v[6]  = 21'h0;
    exp_v[7]  = 21'h0;
    exp_v[8]  = ev(1'b0, 1'b0, 1'b1, CMD_RD, 2'd2, 12'h005, 1'b0, 1'b0);
    exp_v[9]  = 21'h0;
    exp_v[10] = ev(1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    rd_req_bank = 2'd2; rd_req_row = 12'h033; rd_req_col = 12'h005; rd_req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rd_req_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reset_mid_ready: got no ready within 20 cycles, expected ready");
      return;
    end
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 2) reset_poweron = 1'b1;
      else if (i == 3) reset_poweron = 1'b0;
      else if (i == 5) rd_req_valid = 1'b0;
    end
  endtask

  task automatic test_init_drop();
    logic [20:0] exp_v [0:11];
    logic        got;
    exp_v[0]  = ev(1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    exp_v[1]  = ev(1'b0, 1'b0, 1'b1, CMD_RD, 2'd2, 12'h007, 1'b0, 1'b0);
    exp_v[2]  = 21'h0;
    exp_v[3]  = 21'h0;
    exp_v[4]  = 21'h0;
    exp_v[5]  = ev(1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    exp_v[6]  = ev(1'b0, 1'b0, 1'b1, CMD_ACT, 2'd2, 12'h033, 1'b0, 1'b0);
    exp_v[7]  = 21'h0;
    exp_v[8]  = 21'h0;
    exp_v[9]  = ev(1'b0, 1'b0, 1'b1, CMD_RD, 2'd2, 12'h007, 1'b0, 1'b0);
    exp_v[10] = 21'h0;
    exp_v[11] = ev(1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 12'h000, 1'b0, 1'b1);
    rd_req_bank = 2'd2; rd_req_row = 12'h033; rd_req_col = 12'h007; rd_req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rd_req_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL init_drop_ready: got no ready within 20 cycles, expected ready");
      return;
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL init_drop step %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 1) begin rd_req_valid = 1'b0; init_done = 1'b0; end
      else if (i == 3) rd_req_valid = 1'b1;
      else if (i == 4) init_done = 1'b1;
      else if (i == 6) rd_req_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_init_hold();
    test_closed_then_hit();
    repeat (2) @(negedge clk);
    test_conflict_wr();
    repeat (2) @(negedge clk);
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    test_init_drop();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
